// File: rtl/ifu_fetch_buffer_pkg.sv
`default_nettype none
// ifu_fetch_buffer_pkg -- shared defaults and fetch-entry layout for the fetch stage. Rev 1.0
package ifu_fetch_buffer_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_INS_W  = 32;

  localparam logic [DEF_ADDR_W-1:0] DEF_START_ADDR = 64'h8000_0000;
  localparam logic [DEF_INS_W-1:0]  DEF_NOP_INS    = 32'h0000_0013;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INS_W-1:0]  ins;
    logic                  filled;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifu_entry_ram.sv
`default_nettype none
// ifu_entry_ram -- DEPTH-entry pc/instruction store with alloc-write, fill-write and head-read ports. Rev 1.0
module ifu_entry_ram #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int INS_W  = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_en,
  input  logic [IDX_W-1:0]  alloc_idx,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [INS_W-1:0]  fill_ins,
  input  logic [IDX_W-1:0]  head_idx,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INS_W-1:0]  head_ins,
  output logic              head_filled
);

  logic [ADDR_W-1:0] pc_mem  [DEPTH];
  logic [INS_W-1:0]  ins_mem [DEPTH];
  logic [DEPTH-1:0]  filled;

  // Alloc and fill never target the same slot in one cycle: that would need DEPTH in flight and a non-full buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      filled <= '0;
    end else begin
      if (alloc_en) filled[alloc_idx] <= 1'b0;
      if (fill_en)  filled[fill_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en) pc_mem[alloc_idx] <= alloc_pc;
    if (fill_en)  ins_mem[fill_idx] <= fill_ins;
  end

  assign head_pc     = pc_mem[head_idx];
  assign head_ins    = ins_mem[head_idx];
  assign head_filled = filled[head_idx];

endmodule
`default_nettype wire

// File: rtl/ifu_fetch_buffer.sv
`default_nettype none
// ifu_fetch_buffer -- PC-owning fetch stage: multiple outstanding imem requests, in-order buffer,
// redirect with stale-response dropping and NOP bubble injection. Rev 1.0
module ifu_fetch_buffer
  import ifu_fetch_buffer_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                INS_W      = DEF_INS_W,
  parameter int                DEPTH      = 4,
  parameter int                N_BUBBLE   = 3,
  parameter logic [ADDR_W-1:0] START_ADDR = DEF_START_ADDR,
  parameter logic [INS_W-1:0]  NOP_INS    = DEF_NOP_INS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic [N_BUBBLE-1:0] bubble,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_W-1:0]   imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INS_W-1:0]    imem_rsp_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [INS_W-1:0]    out_ins,
  output logic [ADDR_W-1:0]   out_snpc
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  // Stale responses can pile up across back-to-back redirects, so the drop counter gets headroom.
  localparam int DROP_W = PTR_W + 4;

  logic [PTR_W-1:0]  alloc_ptr, fill_ptr, head_ptr;
  logic [ADDR_W-1:0] fetch_pc;
  logic [DROP_W-1:0] drop_cnt;

  logic [PTR_W-1:0]  occupancy, outstanding;
  logic              full, empty;
  logic              req_fire, rsp_drop, rsp_fill, bubble_any, pop;
  logic [ADDR_W-1:0] head_pc;
  logic [INS_W-1:0]  head_ins;
  logic              head_filled;

  assign occupancy   = alloc_ptr - head_ptr;
  assign outstanding = alloc_ptr - fill_ptr;
  assign full        = (occupancy == PTR_W'(DEPTH));
  assign empty       = (alloc_ptr == head_ptr);
  assign bubble_any  = |bubble;

  assign imem_req_valid = !full && !redirect_valid && !reset;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0) && !redirect_valid;
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign pop      = out_valid && out_ready && !bubble_any && !redirect_valid;

  always_comb begin
    out_valid = (!empty && head_filled) || bubble_any;
    out_pc    = head_pc;
    out_ins   = head_ins;
    if (bubble_any) begin
      out_ins = NOP_INS;
      if (empty) out_pc = fetch_pc;
    end
  end

  assign out_snpc = out_pc + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      fetch_pc  <= START_ADDR;
      drop_cnt  <= '0;
    end else if (redirect_valid) begin
      // Everything still owed by memory becomes stale; a response arriving right now is already accounted for.
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      fetch_pc  <= redirect_pc;
      drop_cnt  <= drop_cnt + DROP_W'(outstanding) - DROP_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        alloc_ptr <= alloc_ptr + PTR_W'(1);
        fetch_pc  <= fetch_pc + ADDR_W'(4);
      end
      if (rsp_drop) drop_cnt <= drop_cnt - DROP_W'(1);
      if (rsp_fill) fill_ptr <= fill_ptr + PTR_W'(1);
      if (pop)      head_ptr <= head_ptr + PTR_W'(1);
    end
  end

  ifu_entry_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INS_W  (INS_W)
  ) u_entry_ram (
    .clk         (clk),
    .reset       (reset),
    .alloc_en    (req_fire),
    .alloc_idx   (alloc_ptr[IDX_W-1:0]),
    .alloc_pc    (fetch_pc),
    .fill_en     (rsp_fill),
    .fill_idx    (fill_ptr[IDX_W-1:0]),
    .fill_ins    (imem_rsp_data),
    .head_idx    (head_ptr[IDX_W-1:0]),
    .head_pc     (head_pc),
    .head_ins    (head_ins),
    .head_filled (head_filled)
  );

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_buffer.sv
`default_nettype none
// tb_ifu_fetch_buffer -- directed checks of ifu_fetch_buffer driven by an in-order, fixed-latency memory model. Rev 1.0
module tb_ifu_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [2:0]  bubble;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_ins;
  logic [63:0] out_snpc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  logic [63:0] mq_addr[$];
  int          mq_due[$];
  logic [63:0] pop_pc[$];
  logic [31:0] pop_ins[$];
  logic [63:0] fire_log[$];

  always #5 clk = ~clk;

  ifu_fetch_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bubble         (bubble),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_ins        (out_ins),
    .out_snpc       (out_snpc)
  );

  function automatic logic [31:0] ins_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0003;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // One clock: observe handshakes just before the edge, then present the memory response for the next cycle.
  task automatic tick();
    #1;
    if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
      fire_log.push_back(imem_req_addr);
    end
    if (out_valid && out_ready && !(|bubble) && !redirect_valid && !reset) begin
      pop_pc.push_back(out_pc);
      pop_ins.push_back(out_ins);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ins_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bubble         = '0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    mq_addr.delete();
    mq_due.delete();
    imem_rsp_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    pop_pc.delete();
    pop_ins.delete();
    fire_log.delete();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stale;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bubble         = '0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    tick();
    tick();
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    pop_pc.delete();
    pop_ins.delete();
    fire_log.delete();
    #1;
    check("first_req_valid", 64'(imem_req_valid), 64'd1);
    check("first_req_addr", imem_req_addr, 64'h8000_0000);
    check("first_out_valid", 64'(out_valid), 64'd0);

    // Streaming with 1-cycle memory and decode always ready.
    tick();
    tick();
    check("s_out_valid", 64'(out_valid), 64'd1);
    check("s_out_pc", out_pc, 64'h8000_0000);
    check("s_out_snpc", out_snpc, 64'h8000_0004);
    check("s_out_ins", 64'(out_ins), 64'(ins_of(64'h8000_0000)));
    repeat (4) tick();
    check("s_pop0", pop_pc[0], 64'h8000_0000);
    check("s_pop1", pop_pc[1], 64'h8000_0004);
    check("s_pop2", pop_pc[2], 64'h8000_0008);
    check("s_pop2_ins", 64'(pop_ins[2]), 64'(ins_of(64'h8000_0008)));

    // Decode stalled: buffer fills to DEPTH and requests stop.
    do_reset();
    out_ready = 1'b0;
    repeat (8) tick();
    check("full_req_count", 64'(fire_log.size()), 64'd4);
    check("full_req_first", fire_log[0], 64'h8000_0000);
    check("full_req_last", fire_log[3], 64'h8000_000C);
    check("full_req_valid", 64'(imem_req_valid), 64'd0);
    check("full_head_pc", out_pc, 64'h8000_0000);
    out_ready = 1'b1;
    tick();
    check("resume_req_valid", 64'(imem_req_valid), 64'd1);
    check("resume_req_addr", imem_req_addr, 64'h8000_0010);
    repeat (3) tick();
    check("drain_pop0", pop_pc[0], 64'h8000_0000);
    check("drain_pop3", pop_pc[3], 64'h8000_000C);

    // Redirect with three requests in flight at 3-cycle latency.
    do_reset();
    lat = 3;
    repeat (3) tick();
    check("rd_pre_out_valid", 64'(out_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    repeat (12) tick();
    stale = 0;
    foreach (pop_pc[i]) if (pop_pc[i] < 64'h8000_1000) stale++;
    check("rd_stale_popped", 64'(stale), 64'd0);
    check("rd_pop0_pc", pop_pc[0], 64'h8000_1000);
    check("rd_pop0_ins", 64'(pop_ins[0]), 64'(ins_of(64'h8000_1000)));
    check("rd_pop1_pc", pop_pc[1], 64'h8000_1004);
    lat = 1;

    // Bubble while head holds 0x8000_0008.
    do_reset();
    out_ready = 1'b0;
    repeat (8) tick();
    out_ready = 1'b1;
    tick();
    tick();
    bubble = 3'b010;
    #1;
    check("bub_valid", 64'(out_valid), 64'd1);
    check("bub_ins", 64'(out_ins), 64'h13);
    check("bub_pc", out_pc, 64'h8000_0008);
    check("bub_snpc", out_snpc, 64'h8000_000C);
    tick();
    tick();
    check("bub_hold_pc", out_pc, 64'h8000_0008);
    check("bub_hold_ins", 64'(out_ins), 64'h13);
    bubble = 3'b000;
    #1;
    check("bub_end_ins", 64'(out_ins), 64'(ins_of(64'h8000_0008)));
    check("bub_end_pc", out_pc, 64'h8000_0008);
    tick();
    check("bub_end_pop", pop_pc[2], 64'h8000_0008);

    // PC wrap at the top of the address space; bubble on an empty buffer shows fetch_pc.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    check("wrap_redirect_noreq", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    bubble         = 3'b100;
    #1;
    check("wrap_bub_valid", 64'(out_valid), 64'd1);
    check("wrap_bub_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_bub_snpc", out_snpc, 64'h0);
    bubble = 3'b000;
    check("wrap_req_addr0", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_req_addr1", imem_req_addr, 64'h0);
    tick();
    check("wrap_out_valid", 64'(out_valid), 64'd1);
    check("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_out_snpc", out_snpc, 64'h0);
    check("wrap_out_ins", 64'(out_ins), 64'(ins_of(64'hFFFF_FFFF_FFFF_FFFC)));

    // Redirect coinciding with a response and a decode handshake.
    do_reset();
    repeat (3) tick();
    check("col_rsp_valid", 64'(imem_rsp_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    #1;
    check("col_out_valid", 64'(out_valid), 64'd1);
    check("col_out_pc", out_pc, 64'h8000_0004);
    tick();
    redirect_valid = 1'b0;
    check("col_empty_after", 64'(out_valid), 64'd0);
    check("col_req_addr", imem_req_addr, 64'h8000_2000);
    repeat (4) tick();
    check("col_pop_count_ge2", 64'(pop_pc.size() >= 2), 64'd1);
    check("col_pop1_pc", pop_pc[1], 64'h8000_2000);
    check("col_pop1_ins", 64'(pop_ins[1]), 64'(ins_of(64'h8000_2000)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
